// File: rtl/cpr_pkg.sv
// Shared definitions for the RV32M multiply/divide coprocessor.
// Provides the operand width, the FCT3 opcodes, the FCT7 values that route
// coprocessor requests (MULDIV vs FPU), and the controller state encoding.
package cpr_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [6:0] CPR_FCT7_FPU    = 7'b0000000;
    localparam logic [6:0] CPR_FCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } cpr_state_e;

endpackage

// File: rtl/cpr_muldiv_if.sv
// Coprocessor request port between the CPU (master) and the mul/div unit
// (slave).
//   cs     : request select (CPR_REQ qualified by FCT7)
//   func   : FCT3 opcode
//   rs1/2  : operands
//   ready  : one-cycle completion strobe
//   result : registered result
interface cpr_muldiv_if;
    import cpr_pkg::*;

    logic            cs;
    logic [2:0]      func;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            ready;
    logic [XLEN-1:0] result;

    modport master (output cs, func, rs1, rs2, input ready, result);
    modport slave  (input cs, func, rs1, rs2, output ready, result);

endinterface

// File: rtl/cpr_muldiv.sv
// Iterative RV32M multiply/divide coprocessor, one bit per clock.
// Ports:
//   clk     : CPU clock
//   n_reset : asynchronous active-low reset
//   bus     : coprocessor request port (slave side)
// Multiply and divide share one 64-bit accumulator and one 33-bit
// adder/subtractor. Operands are converted to magnitudes on entry and the
// sign is restored in FIX.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for cs; latch operands, or load special-case result
// BUSY    | 32 shift-add / shift-subtract iterations
// FIX     | apply sign correction, load result
// DONE    | ready high for one cycle
module cpr_muldiv
    import cpr_pkg::*;
(
    input  logic         clk,
    input  logic         n_reset,
    cpr_muldiv_if.slave  bus
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    cpr_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        func_q, func_d;
    logic              neg1_q, neg1_d;
    logic              neg2_q, neg2_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              ready_q, ready_d;

    // request decode, only meaningful in IDLE
    logic            req_div;
    logic            rs1_signed, rs2_signed;
    logic            neg1_in, neg2_in;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign req_div    = bus.func[2];
    assign rs1_signed = (bus.func == MULH) || (bus.func == MULHSU) ||
                        (bus.func == DIV)  || (bus.func == REM);
    assign rs2_signed = (bus.func == MULH) || (bus.func == DIV) || (bus.func == REM);
    assign neg1_in    = rs1_signed & bus.rs1[XLEN-1];
    assign neg2_in    = rs2_signed & bus.rs2[XLEN-1];
    assign abs1       = neg1_in ? -bus.rs1 : bus.rs1;
    assign abs2       = neg2_in ? -bus.rs2 : bus.rs2;
    assign div_zero   = req_div && (bus.rs2 == '0);
    assign div_ovf    = ((bus.func == DIV) || (bus.func == REM)) &&
                        (bus.rs1 == MIN_INT) && (bus.rs2 == '1);
    assign special    = div_zero | div_ovf;
    // func[1] separates REM/REMU from DIV/DIVU
    assign special_res = div_zero ? (bus.func[1] ? bus.rs1 : '1)
                                  : (bus.func[1] ? '0 : MIN_INT);

    // shared 33-bit adder: multiply adds the multiplicand to the upper half,
    // divide subtracts the divisor from the remainder shifted left by one
    logic              add_sub;
    logic [XLEN:0]     add_a, add_b, add_sum;

    assign add_sub = func_q[2];
    assign add_a   = add_sub ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
    assign add_b   = {1'b0, opb_q} ^ {(XLEN+1){add_sub}};
    assign add_sum = add_a + add_b + {{XLEN{1'b0}}, add_sub};

    // sign correction
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, fix_res;

    assign prod = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
    assign quot = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem  = neg1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        case (func_q)
            MUL:                  fix_res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            DIV, DIVU:            fix_res = quot;
            default:              fix_res = rem;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            func_q   <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            func_q   <= func_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.cs) state_d = special ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (!bus.cs)       state_d = ST_IDLE;
                // all-ones count is the last of the 32 iterations
                else if (&count_q) state_d = ST_FIX;
            end
            ST_FIX:  state_d = bus.cs ? ST_DONE : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        func_d   = func_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        ready_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cs) begin
                    func_d  = bus.func;
                    neg1_d  = neg1_in;
                    neg2_d  = neg2_in;
                    count_d = '0;
                    if (req_div) begin
                        acc_d = {{XLEN{1'b0}}, abs1};
                        opb_d = abs2;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, abs2};
                        opb_d = abs1;
                    end
                    if (special) begin
                        result_d = special_res;
                        ready_d  = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.cs) begin
                    count_d = count_q + 1'b1;
                    if (!add_sub) begin
                        // multiplier bit is acc[0]; shift right with carry-in
                        acc_d = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]}
                                         : {1'b0, acc_q[2*XLEN-1:1]};
                    end else begin
                        // borrow out of the trial subtract means restore
                        acc_d = add_sum[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                              : {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end
                end
            end
            ST_FIX: begin
                if (bus.cs) begin
                    result_d = fix_res;
                    ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ready  = ready_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_cpr_muldiv.sv
module tb_cpr_muldiv;
    import cpr_pkg::*;

    logic clk;
    logic n_reset;
    int   checks;
    int   errors;

    cpr_muldiv_if bus();

    cpr_muldiv dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // returns the number of edges until ready is seen, 0 on timeout
    task automatic wait_ready(input int limit, output int lat);
        lat = 0;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bus.func = f;
        bus.rs1  = a;
        bus.rs2  = b;
        bus.cs   = 1'b1;
        wait_ready(60, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, bus.result, exp);
        bus.cs = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_rdy_pulse"}, {31'b0, bus.ready}, 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        checks  = 0;
        errors  = 0;
        n_reset = 1'b0;
        bus.cs  = 1'b0;
        bus.func = 3'd0;
        bus.rs1 = '0;
        bus.rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, bus.ready}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        n_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ready", {31'b0, bus.ready}, 32'd0);

        run_op("mul",    MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulh",   MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhu",  MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("div",    DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem",    REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("divu",   DIVU,   32'd100,        32'd7,         32'd14,        34);
        run_op("remu",   REMU,   32'd100,        32'd7,         32'd2,         34);
        run_op("div0",   DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem0",   REM,    32'd5,          32'd0,         32'd5,         1);
        run_op("divovf", DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // back-to-back with cs held high
        bus.func = MULHU;
        bus.rs1  = 32'hFFFF_FFFF;
        bus.rs2  = 32'hFFFF_FFFF;
        bus.cs   = 1'b1;
        wait_ready(60, lat);
        chk("b2b_first_lat", 32'(lat), 32'd34);
        chk("b2b_first_res", bus.result, 32'hFFFF_FFFE);
        bus.func = DIVU;
        bus.rs1  = 32'd100;
        bus.rs2  = 32'd7;
        wait_ready(60, lat);
        chk("b2b_second_gap", 32'(lat), 32'd35);
        chk("b2b_second_res", bus.result, 32'd14);
        bus.cs = 1'b0;
        @(posedge clk);
        #1;

        // reset during a divide
        bus.func = DIV;
        bus.rs1  = 32'hFFFF_FFF9;
        bus.rs2  = 32'd2;
        bus.cs   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_reset = 1'b0;
        #1;
        chk("midrst_result", bus.result, 32'd0);
        chk("midrst_ready", {31'b0, bus.ready}, 32'd0);
        bus.cs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("postrst_ready", {31'b0, bus.ready}, 32'd0);
        run_op("mul_3x4", MUL, 32'd3, 32'd4, 32'd12, 34);

        // cs dropped mid-operation
        bus.func = DIVU;
        bus.rs1  = 32'd100;
        bus.rs2  = 32'd7;
        bus.cs   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.cs = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready) seen++;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        chk("abort_result_kept", bus.result, 32'd12);
        run_op("after_abort", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpr_muldiv.md
# cpr_muldiv

Iterative RV32M multiply/divide coprocessor answering the CPU's custom-instruction coprocessor request port. Selected when the request carries FCT7 = 7'b0000001, beside the FPU which owns FCT7 = 0. Holds the CPU halted until its result is ready, then presents the result for one cycle. Single shared shift-add / shift-subtract datapath: one bit per clock.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  CPU clock (gated cpu_clk at top level).
- n_reset  in  1  asynchronous active-low reset (driven from cpu_n_reset).
- cs  in  1  request select; top level drives CPR_REQ & (CPR_FCT7 == 7'b0000001).
- func  in  3  CPR_FCT3, the RV32M encoding:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1  in  XLEN  first operand (CPR_RS1).
- rs2  in  XLEN  second operand (CPR_RS2).
- ready  out  1  one-cycle completion strobe.
- result  out  XLEN  registered result (CPR_RDR).

## Operation
- Top level: cpr_hlt includes cs & ~ready.
- CPU contract while halted: func, rs1 and rs2 stay stable while cs = 1 and ready = 0.
- CPU contract after completion: cs = 1 in the cycle after ready is a new request.
- FSM states: IDLE, BUSY, FIX, DONE.
- IDLE, cs = 1: latch func; latch |rs1| and |rs2| according to signedness.
  - Signed operands: rs1 for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
  - Record negative flags.
  - Clear count; go to BUSY.
- IDLE, divide special cases: go directly to DONE with the final result loaded.
  - rs2 = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - DIV with rs1 = 0x80000000, rs2 = 0xFFFFFFFF: result 0x80000000; REM gives 0.
- BUSY, multiply: 64-bit shift-add, LSB-first on the multiplier. 32 cycles.
- BUSY, divide: restoring divide, MSB-first, 33-bit trial subtract. 32 cycles.
- BUSY: when count reaches 31, go to FIX.
- FIX, sign correction:
  - Product: negate the 64-bit value when the operand-sign XOR is set. MUL takes the low word; MULH* take the high word.
  - Quotient sign = neg1 ^ neg2; remainder sign = neg1.
  - Load result; go to DONE.
- DONE: ready = 1 for exactly one cycle, then IDLE. This applies even if cs has dropped.
- cs = 0 in BUSY or FIX: abort to IDLE on the next edge. No ready; result unchanged.
- result holds its value until the next FIX or special-case load.

## Timing
- Reset values (asynchronous): state IDLE, ready 0, result 0, count 0, internal accumulators 0.
- Normal latency: cs first high in cycle 0 (IDLE); BUSY cycles 1–32; FIX cycle 33; ready = 1 in cycle 34.
- Special-case latency: ready = 1 in cycle 1.
- Back-to-back: if cs = 1 in the cycle after ready, that cycle is the next request's cycle 0.
- Reset asserted mid-operation: outputs return to reset values immediately; no ready is produced.
- After reset release: the block stays in IDLE until cs = 1.
- Combinational input-to-output paths: none. ready and result are both flops.

## Structure
- Shared package cpr_pkg:
  - FCT3 localparams MUL…REMU.
  - CPR_FCT7_MULDIV = 7'b0000001 (and CPR_FCT7_FPU = 0).
  - XLEN.
  - State encoding.
- Single module, no sub-module. The multiply and divide paths share the 64-bit accumulator register and the 33-bit adder/subtractor.
- Counter width: $clog2(XLEN).

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD: result = 0xFFFFFFEB; ready exactly in cycle 34, high for one cycle.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Divides:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, ready in cycle 1:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Back-to-back: MULHU then DIVU with cs held high throughout.
  - Both results are correct.
  - The second ready comes 35 cycles after the first.
- Interruptions:
  - n_reset low at cycle 10 of a DIV: result = 0 and ready = 0 at once; a new MUL 3×4 after release → 12.
  - cs dropped at cycle 5: no ready; result unchanged.
